hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard controller that drives the stall, hold and flush inputs of the 5-stage pipeline registers. It detects load-use hazards between ID and EX and squashes wrong-path instructions on taken branches resolved in EX. It also freezes the pipeline while a data-memory access in MEM is not ready, with a timeout trap. Its `idex_flush` output feeds the ID/EX register's synchronous flush input, which zeroes all ID/EX contents at the next clock edge.

## Interface
- `MEM_TIMEOUT`, default 16: consecutive not-ready memory cycles tolerated before trapping. Legal range is ≥2.
- `CNT_W`, default 16: width of the performance counters.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `idex_mem_read`  in  1  the instruction in EX is a load.
- `idex_rd`  in  5  destination register of the instruction in EX.
- `ifid_rs1`, `ifid_rs2`  in  5 each  source registers of the instruction in ID.
- `ifid_uses_rs2`  in  1  the instruction in ID reads rs2 (R/S/B type).
- `branch_taken`  in  1  the branch in EX is taken; PC loads the target this cycle.
- `dmem_req`  in  1  the instruction in MEM accesses data memory.
- `dmem_ready`  in  1  the data memory completes the access this cycle.
- `pc_write`  out  1  PC register enable.
- `ifid_write`  out  1  IF/ID register enable.
- `ifid_flush`  out  1  IF/ID is zeroed (becomes a NOP) at the next edge.
- `idex_flush`  out  1  ID/EX is zeroed (becomes a bubble) at the next edge.
- `pipe_hold`  out  1  ID/EX, EX/MEM and MEM/WB keep their values at the next edge.
- `mem_timeout`  out  1  sticky trap flag.
- `stall_cycles`  out  CNT_W  count of cycles in which `pc_write` was 0.
- `flush_count`  out  CNT_W  count of branch flushes.

## Operation
- States: RUN, MEM_WAIT, TRAP. Registered state plus `wait_cnt`, which is wide enough to hold `MEM_TIMEOUT`.
- `mem_stall` is `dmem_req & ~dmem_ready`.
- `load_use` is `idex_mem_read & (idex_rd != 0) & ((idex_rd == ifid_rs1) | (ifid_uses_rs2 & (idex_rd == ifid_rs2)))`.
- Control outputs are combinational (Mealy) and evaluated in this priority order:
  1. **TRAP or mem_stall (freeze):** `pc_write`=0, `ifid_write`=0, `pipe_hold`=1, both flushes 0. Branch and load-use are ignored this cycle; the EX contents are held, so a pending branch is re-evaluated after release.
  2. **branch_taken:** `pc_write`=1, `ifid_write`=1, `ifid_flush`=1, `idex_flush`=1, `pipe_hold`=0. Branch wins over load-use because the ID instruction is squashed anyway.
  3. **load_use:** `pc_write`=0, `ifid_write`=0, `idex_flush`=1, `ifid_flush`=0, `pipe_hold`=0. Exactly one bubble is inserted, since the load has left EX by the next cycle.
  4. **Otherwise:** `pc_write`=1, `ifid_write`=1, all flushes 0, `pipe_hold`=0.
- State transitions:
  - RUN: on `mem_stall`, go to MEM_WAIT with `wait_cnt`=1. Otherwise stay in RUN.
  - MEM_WAIT: if `~mem_stall`, go to RUN and clear `wait_cnt`. If `mem_stall` and `wait_cnt == MEM_TIMEOUT-1`, go to TRAP. Otherwise increment `wait_cnt`.
  - TRAP: absorbing; only `rst` exits. `mem_timeout` is 1 in TRAP, otherwise 0.
- Counters:
  - `stall_cycles` increments on every edge at which `pc_write` was 0, including freeze, load-use and TRAP cycles.
  - `flush_count` increments on every edge at which the branch-flush case (2) applied.
  - Both counters saturate at all-ones and never wrap.
- `idex_rd` == 0 never creates a hazard, whatever the rs values.

## Timing
- While `rst` is high:
  - State is RUN and `wait_cnt`, both counters and `mem_timeout` are 0.
  - Outputs are forced to `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `idex_flush`=1, `pipe_hold`=0, so the downstream registers clear to bubbles.
- Reset is asynchronous: asserting `rst` mid-freeze or in TRAP returns to RUN immediately. Outputs take their normal values in the first cycle after deassertion.
- Latency:
  - Load-use costs exactly 1 stall cycle.
  - A taken branch costs 2 squashed instructions (IF/ID and ID/EX) and no stall cycle.
  - A memory wait of N not-ready cycles costs N freeze cycles, with release in the same cycle `dmem_ready` rises.
- Timeout boundary: with `dmem_ready` low for `MEM_TIMEOUT` consecutive cycles, the edge ending the `MEM_TIMEOUT`-th cycle enters TRAP. `dmem_ready` rising in that same cycle prevents the trap.
- Simultaneous events:
  - `mem_stall` with `branch_taken`: freeze; the flush occurs in the first non-stalled cycle.
  - `mem_stall` with `load_use`: freeze; the bubble is inserted after release.

## Test plan
- Load-use with `idex_mem_read`=1, `idex_rd`=5, `ifid_rs1`=5: that cycle `pc_write`=0, `ifid_write`=0, `idex_flush`=1. Next cycle (`idex_mem_read`=0) all enables are 1. `stall_cycles` goes 0→1.
- Same as above with `idex_rd`=0, or with a `ifid_rs2` match while `ifid_uses_rs2`=0: no stall, `pc_write`=1.
- `branch_taken`=1 together with a load-use condition: `ifid_flush`=1, `idex_flush`=1, `pc_write`=1. `flush_count` goes 0→1 and `stall_cycles` is unchanged.
- Memory wait: `dmem_req`=1 with `dmem_ready` low for 3 cycles, then high, with `branch_taken` held at 1.
  - Required: 3 freeze cycles with `pipe_hold`=1 and no flush.
  - On release: flushes assert in the cycle `dmem_ready`=1, and `stall_cycles`=3.
- With `MEM_TIMEOUT`=8:
  - `dmem_ready` low for 8 cycles: `mem_timeout`=1 after the 8th edge, the pipeline stays frozen, and asserting `rst` clears it.
  - `dmem_ready` rising in cycle 8: no trap.
- Counter saturation with `CNT_W`=4: 20 load-use cycles leave `stall_cycles`=15. Asserting `rst` mid-freeze clears it to 0 and forces both flushes to 1.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, branch squash and memory-wait freeze
// with a timeout trap, plus saturating stall/flush performance counters.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          mem_stall, load_use, freeze, branch_flush;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = idex_mem_read & (idex_rd != 5'd0) &
                     ((idex_rd == ifid_rs1) | (ifid_uses_rs2 & (idex_rd == ifid_rs2)));
  assign freeze       = (state == TRAP) | mem_stall;
  assign branch_flush = ~rst & ~freeze & branch_taken;
  assign mem_timeout  = (state == TRAP);

  // Reset forces bubbles into IF/ID and ID/EX so the pipe comes up clean.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WW'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
          state_nxt = TRAP;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Counters saturate so long runs never alias back to small values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (branch_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Table-driven bench for hazard_control_unit (MEM_TIMEOUT=8, CNT_W=4) with a
// queue scoreboard of expected outputs and a small saturating counter model.
module tb_hazard_control_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          idex_mem_read, ifid_uses_rs2, branch_taken, dmem_req, dmem_ready;
  logic [4:0]    idex_rd, ifid_rs1, ifid_rs2;
  logic          pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  hazard_control_unit #(.MEM_TIMEOUT(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, mr;
    logic [4:0] rd, rs1, rs2;
    logic       u2, br, req, rdy;
    logic [5:0] exp; // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_timeout}
  } vec_t;

  typedef struct {
    logic [5:0]    outs;
    logic [CW-1:0] stall, flush;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] m_stall = '0, m_flush = '0;

  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] LU   = 6'b000100;
  localparam logic [5:0] BR   = 6'b111100;
  localparam logic [5:0] FRZ  = 6'b000010;
  localparam logic [5:0] TRP  = 6'b000011;
  localparam logic [5:0] RSTO = 6'b001100;

  function automatic vec_t mk(logic r, logic mr, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic u2, logic br, logic req,
                              logic rdy, logic [5:0] e);
    vec_t v;
    v.rst = r; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2;
    v.br = br; v.req = req; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  // Drive just after a rising edge, sample late in the same cycle.
  task automatic apply(input vec_t v, input string name);
    exp_t e, got;
    logic [5:0] act;
    rst = v.rst; idex_mem_read = v.mr; idex_rd = v.rd; ifid_rs1 = v.rs1;
    ifid_rs2 = v.rs2; ifid_uses_rs2 = v.u2; branch_taken = v.br;
    dmem_req = v.req; dmem_ready = v.rdy;
    if (v.rst) begin m_stall = '0; m_flush = '0; end
    e.outs = v.exp; e.stall = m_stall; e.flush = m_flush;
    sb.push_back(e);
    #7;
    got = sb.pop_front();
    n_vec++;
    act = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_timeout};
    if (act !== got.outs) begin
      n_err++;
      $display("FAIL %s outs: got %b expected %b", name, act, got.outs);
    end
    if (stall_cycles !== got.stall || flush_count !== got.flush) begin
      n_err++;
      $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               name, stall_cycles, flush_count, got.stall, got.flush);
    end
    if (!v.rst) begin
      if (!v.exp[5] && m_stall != '1) m_stall = m_stall + 1'b1;
      if (v.exp[3] && v.exp[2] && m_flush != '1) m_flush = m_flush + 1'b1;
    end
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, RSTO));  // reset
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, NORM));  // idle
    tbl.push_back(mk(0,1,5,5,0,0,0,0,0, LU));    // rs1 load-use
    tbl.push_back(mk(0,0,5,5,0,0,0,0,0, NORM));  // load gone
    tbl.push_back(mk(0,1,0,0,0,1,0,0,0, NORM));  // rd=0 never hazards
    tbl.push_back(mk(0,1,7,3,7,0,0,0,0, NORM));  // rs2 match, rs2 unused
    tbl.push_back(mk(0,1,7,3,7,1,0,0,0, LU));    // rs2 match, rs2 used
    tbl.push_back(mk(0,1,9,9,0,0,1,0,0, BR));    // branch beats load-use
    tbl.push_back(mk(0,0,0,0,0,0,1,0,1, BR));    // req low: ready ignored
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, RSTO));  // reset before mem wait
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,0,0,0,1,1,0, FRZ)); // frozen, branch deferred
    tbl.push_back(mk(0,0,0,0,0,0,1,1,1, BR));    // release: flush same cycle
    tbl.push_back(mk(0,1,4,0,4,1,0,1,0, FRZ));   // stall beats load-use
    tbl.push_back(mk(0,1,4,0,4,1,0,1,1, LU));    // bubble after release
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, NORM));

    rst = 1'b1;
    {idex_mem_read, ifid_uses_rs2, branch_taken, dmem_req, dmem_ready} = '0;
    idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
    @(posedge clk); #1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // Timeout: eight not-ready cycles trap; trap holds until reset.
    apply(mk(1,0,0,0,0,0,0,0,0, RSTO), "to_rst");
    for (int i = 0; i < 8; i++) apply(mk(0,0,0,0,0,0,0,1,0, FRZ), $sformatf("to_wait%0d", i));
    apply(mk(0,0,0,0,0,0,1,0,0, TRP), "to_trap");
    apply(mk(0,1,3,3,0,0,0,0,0, TRP), "to_trap2");
    #3 rst = 1'b1; #1;
    if ({pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_timeout} !== RSTO) begin
      n_err++;
      $display("FAIL trap_async_rst: got %b expected %b",
               {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_timeout}, RSTO);
    end
    n_vec++;
    @(posedge clk); #1;
    apply(mk(1,0,0,0,0,0,0,0,0, RSTO), "to_rst2");

    // Ready in the 8th cycle avoids the trap.
    for (int i = 0; i < 7; i++) apply(mk(0,0,0,0,0,0,0,1,0, FRZ), $sformatf("nt_wait%0d", i));
    apply(mk(0,0,0,0,0,0,0,1,1, NORM), "nt_release");
    apply(mk(0,0,0,0,0,0,0,0,0, NORM), "nt_after");

    // Saturation: 20 load-use cycles leave stall_cycles at 15.
    for (int i = 0; i < 20; i++) apply(mk(0,1,6,6,0,0,0,0,0, LU), $sformatf("sat%0d", i));
    apply(mk(0,0,0,0,0,0,0,1,0, FRZ), "sat_frz");
    #3 rst = 1'b1; #1;
    n_vec++;
    if (stall_cycles !== '0 || ifid_flush !== 1'b1 || idex_flush !== 1'b1) begin
      n_err++;
      $display("FAIL midfreeze_rst: got stall=%0d iff=%b idf=%b expected stall=0 iff=1 idf=1",
               stall_cycles, ifid_flush, idex_flush);
    end
    @(posedge clk); #1;
    apply(mk(1,0,0,0,0,0,0,1,0, RSTO), "sat_rst");
    apply(mk(0,0,0,0,0,0,0,0,0, NORM), "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
